acq_bank_ctrl: RTL and testbench
================================

Name: acq_bank_ctrl

Overview:
- Write-side sequencer for the two 200-word ping-pong channel memory banks drained by the serial readout FSM.
- Detects an acoustic-emission (AE) event from the trigger level and streams samples into alternating banks.
- Signals bank-full, end-of-memorization and the final write index to the readout side.
- Blocks writes into a bank that has not yet been released by the readout.

Parameters:
- DEPTH, 200, words per bank; last index is DEPTH-1.
- HOLDOFF, 16, consecutive below-threshold sample strobes that end an event (1..255).
- MIN_LEN, 4, minimum event length in samples; used only with ACQ_MIN_LEN_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- trigger  in  1  AE detector level; 1 while the signal is above threshold
- sample_valid  in  1  one-cycle strobe per ADC sample
- bank_release  in  1  one-cycle pulse from the readout: the bank named by release_bank has been fully read
- release_bank  in  1  bank index qualified by bank_release
- we  out  1  memory write enable
- waddr  out  9  bit 8 = write bank, bits 7:0 = word index
- bank0_full, bank1_full  out  1  one-cycle pulse when that bank's word DEPTH-1 is written
- memorization_completed  out  1  one-cycle registered pulse at event end
- idx_final  out  8  index of the last word written in the final partial bank
- overflow  out  1  sticky flag; samples were dropped
- state  out  2  current FSM state, for debug

Behaviour:
- Reset values:
  - state = IDLE; we = 0; waddr = 0 (bank 0, index 0); all pulse outputs = 0; idx_final = 0; overflow = 0.
  - Internal pending[1:0] = 0; holdoff counter = 0.
- States:
  - IDLE: on sample_valid && trigger -> WRITE. The triggering sample is written in the same cycle.
  - WRITE: each sample_valid writes one word. trigger = 0 on a strobe -> TAIL with holdoff count = 1.
  - TAIL: sample_valid continues to write.
    - trigger = 1 on a strobe: holdoff count cleared, -> WRITE.
    - trigger = 0 on a strobe: count + 1. When the count reaches HOLDOFF -> DONE. That strobe's sample is still written.
  - DONE: one cycle. Pulses memorization_completed, then -> IDLE.
- Write timing:
  - we and waddr are registered: asserted in the cycle after sample_valid, one cycle wide.
  - The index increments after every accepted write.
- Bank wrap:
  - Writing index DEPTH-1 pulses bankN_full in the same cycle as that we.
  - It also sets pending[N]; the next write goes to the other bank, index 0.
- idx_final:
  - Updated on every write to that write's index.
  - Stable from one cycle before memorization_completed rises until the next event's first write. The readout latches it on the rising edge.
- Event end with an empty current bank (last write was DEPTH-1): memorization_completed is suppressed. The event ends at that bankN_full.
- Event end with a partial bank:
  - Sets pending on the current bank.
  - Next event starts in the other bank at index 0.
- Back-pressure: an accepted sample whose target bank has pending = 1 is dropped.
  - we stays 0 and the index holds.
  - overflow is set and stays set until reset.
  - The FSM keeps tracking trigger/holdoff normally.
- Release:
  - bank_release clears pending[release_bank].
  - If it arrives in the same cycle a write wraps into that bank, the release wins and the write proceeds.
  - A release of a bank that is not pending is ignored.
- Simultaneous bankN_full and event end on the same strobe (HOLDOFF-th low strobe writes DEPTH-1): bankN_full pulses and memorization_completed is suppressed, per the empty-bank rule.
- Reset mid-event: everything returns to reset values immediately. Pending flags are lost; the readout is reset alongside.

Optional Feature:
- Macro ACQ_MIN_LEN_EN.
- Defined: an event totalling fewer than MIN_LEN written samples produces no memorization_completed and sets no pending bit. The write index rewinds to the event's start index in the same bank, and overflow is unaffected.
- Undefined: every event of length ≥ 1 completes normally; MIN_LEN is unused.

Test Plan:
- Reset, 10 triggered strobes, then 16 low strobes -> 26 writes to bank 0 idx 0..25; memorization_completed one pulse with idx_final = 25; next event starts at waddr = 9'h100.
- Event of 450 samples -> bank0_full after idx 199, bank1_full after second idx 199, final partial in bank 0 idx 0..49 only if bank 0 was released; otherwise overflow = 1 and no writes to bank 0.
- Trigger drops for 10 strobes, rises, then drops for 16 -> single event, one memorization_completed, no premature end.
- HOLDOFF-th low strobe lands on idx 199 -> bank0_full pulse, no memorization_completed, state returns to IDLE.
- bank_release for bank 1 coincident with a wrap into bank 1 -> write at waddr 9'h100 occurs, overflow stays 0.
- With ACQ_MIN_LEN_EN, a 2-sample event (with HOLDOFF = 1) -> no completion pulse; next event reuses the same start index.

Source files
------------

// File: rtl/acq_bank_ctrl.sv
// rtl/acq_bank_ctrl.sv - write-side sequencer for the two ping-pong channel banks of an AE capture
// Optional build macro ACQ_MIN_LEN_EN: discard events shorter than MIN_LEN written samples.
module acq_bank_ctrl #(
    parameter int DEPTH   = 200,
    parameter int HOLDOFF = 16,
    parameter int MIN_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic       sample_valid,
    input  logic       bank_release,
    input  logic       release_bank,
    output logic       we,
    output logic [8:0] waddr,
    output logic       bank0_full,
    output logic       bank1_full,
    output logic       memorization_completed,
    output logic [7:0] idx_final,
    output logic       overflow,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_TAIL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);
    localparam logic [7:0] HOLD_CNT = 8'(HOLDOFF);

    state_t     r_state;
    logic       r_bank;
    logic [7:0] r_idx;
    logic [7:0] r_hold;
    logic [1:0] r_pending;
    logic       r_we;
    logic [8:0] r_waddr;
    logic       r_full0;
    logic       r_full1;
    logic       r_done;
    logic [7:0] r_idx_final;
    logic       r_overflow;

    logic       w_accept;
    logic       w_rel_hit;
    logic       w_blocked;
    logic       w_do_write;
    logic       w_wrap;
    logic       w_keep;
    logic [1:0] w_rel_mask;
    logic [1:0] w_pend_set;

    // A sample belongs to the event if it starts one or arrives while one is open.
    assign w_accept   = sample_valid &&
                        ((r_state == S_WRITE) || (r_state == S_TAIL) ||
                         ((r_state == S_IDLE) && trigger));
    // A release landing on the same cycle as a write into that bank frees it in time.
    assign w_rel_hit  = bank_release && (release_bank == r_bank);
    assign w_blocked  = r_pending[r_bank] && !w_rel_hit;
    assign w_do_write = w_accept && !w_blocked;
    assign w_wrap     = (r_idx == LAST_IDX);
    assign w_rel_mask = bank_release ? (release_bank ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        w_pend_set = 2'b00;
        if (w_do_write && w_wrap)
            w_pend_set[r_bank] = 1'b1;
        if ((r_state == S_DONE) && w_keep && (r_idx != 8'd0))
            w_pend_set[r_bank] = 1'b1;
    end

`ifdef ACQ_MIN_LEN_EN
    logic       r_ev_bank;
    logic [7:0] r_ev_idx;
    logic [7:0] r_ev_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ev_bank <= 1'b0;
            r_ev_idx  <= 8'd0;
            r_ev_len  <= 8'd0;
        end else if ((r_state == S_IDLE) && sample_valid && trigger) begin
            r_ev_bank <= r_bank;
            r_ev_idx  <= r_idx;
            r_ev_len  <= w_do_write ? 8'd1 : 8'd0;
        end else if (w_do_write && (r_ev_len != 8'hFF)) begin
            r_ev_len  <= r_ev_len + 8'd1;
        end
    end

    assign w_keep = (r_ev_len >= 8'(MIN_LEN));
`else
    logic w_unused_min_len;
    assign w_unused_min_len = (MIN_LEN > 0);
    assign w_keep           = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bank      <= 1'b0;
            r_idx       <= 8'd0;
            r_hold      <= 8'd0;
            r_pending   <= 2'b00;
            r_we        <= 1'b0;
            r_waddr     <= 9'd0;
            r_full0     <= 1'b0;
            r_full1     <= 1'b0;
            r_done      <= 1'b0;
            r_idx_final <= 8'd0;
            r_overflow  <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_full0   <= 1'b0;
            r_full1   <= 1'b0;
            r_done    <= 1'b0;
            r_pending <= (r_pending & ~w_rel_mask) | w_pend_set;

            if (w_accept && w_blocked)
                r_overflow <= 1'b1;

            if (w_do_write) begin
                r_we        <= 1'b1;
                r_waddr     <= {r_bank, r_idx};
                r_idx_final <= r_idx;
                if (w_wrap) begin
                    r_full0 <= ~r_bank;
                    r_full1 <= r_bank;
                    r_bank  <= ~r_bank;
                    r_idx   <= 8'd0;
                end else begin
                    r_idx   <= r_idx + 8'd1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (sample_valid && trigger) begin
                        r_state <= S_WRITE;
                        r_hold  <= 8'd0;
                    end
                end
                S_WRITE: begin
                    if (sample_valid && !trigger) begin
                        r_hold  <= 8'd1;
                        r_state <= (HOLD_CNT == 8'd1) ? S_DONE : S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (sample_valid) begin
                        if (trigger) begin
                            r_hold  <= 8'd0;
                            r_state <= S_WRITE;
                        end else begin
                            r_hold <= r_hold + 8'd1;
                            if ((r_hold + 8'd1) == HOLD_CNT)
                                r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_hold  <= 8'd0;
                    // An event ending exactly on a bank boundary was already handed over by bankN_full.
                    if (w_keep) begin
                        if (r_idx != 8'd0) begin
                            r_done <= 1'b1;
                            r_bank <= ~r_bank;
                            r_idx  <= 8'd0;
                        end
                    end
`ifdef ACQ_MIN_LEN_EN
                    else begin
                        r_bank <= r_ev_bank;
                        r_idx  <= r_ev_idx;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign we                     = r_we;
    assign waddr                  = r_waddr;
    assign bank0_full             = r_full0;
    assign bank1_full             = r_full1;
    assign memorization_completed = r_done;
    assign idx_final              = r_idx_final;
    assign overflow               = r_overflow;
    assign state                  = r_state;

endmodule

// File: tb/tb_acq_bank_ctrl.sv
// tb/tb_acq_bank_ctrl.sv - scoreboard bench for acq_bank_ctrl in its default build
module tb_acq_bank_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       trigger;
    logic       sample_valid;
    logic       bank_release;
    logic       release_bank;
    logic       we;
    logic [8:0] waddr;
    logic       bank0_full;
    logic       bank1_full;
    logic       memorization_completed;
    logic [7:0] idx_final;
    logic       overflow;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;
    int n_we     = 0;
    int n_done   = 0;

    logic [8:0] exp_addr[$];
    logic [7:0] exp_fin[$];

    acq_bank_ctrl dut (
        .clk                    (clk),
        .reset                  (reset),
        .trigger                (trigger),
        .sample_valid           (sample_valid),
        .bank_release           (bank_release),
        .release_bank           (release_bank),
        .we                     (we),
        .waddr                  (waddr),
        .bank0_full             (bank0_full),
        .bank1_full             (bank1_full),
        .memorization_completed (memorization_completed),
        .idx_final              (idx_final),
        .overflow               (overflow),
        .state                  (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write and completion must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (we) begin
                n_we++;
                chk("write_expected", 32'(exp_addr.size() > 0), 32'd1);
                if (exp_addr.size() > 0)
                    chk("waddr", 32'(waddr), 32'(exp_addr.pop_front()));
            end
            if (we || bank0_full || bank1_full) begin
                chk("bank0_full", 32'(bank0_full), 32'(we && (waddr == 9'h0C7)));
                chk("bank1_full", 32'(bank1_full), 32'(we && (waddr == 9'h1C7)));
            end
            if (memorization_completed) begin
                n_done++;
                chk("done_expected", 32'(exp_fin.size() > 0), 32'd1);
                if (exp_fin.size() > 0)
                    chk("idx_final", 32'(idx_final), 32'(exp_fin.pop_front()));
            end
        end
    end

    task automatic push_range(input logic bank, input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            exp_addr.push_back({bank, 8'(i)});
    endtask

    task automatic strobe(input logic trig, input logic rel, input logic rb);
        sample_valid = 1'b1;
        trigger      = trig;
        bank_release = rel;
        release_bank = rb;
        @(negedge clk);
        sample_valid = 1'b0;
        bank_release = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_only(input logic rb);
        bank_release = 1'b1;
        release_bank = rb;
        @(negedge clk);
        bank_release = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_event(input int nhigh, input int nlow, input int rel_at, input logic rb);
        for (int i = 0; i < nhigh + nlow; i++)
            strobe(i < nhigh, i == rel_at, rb);
    endtask

    task automatic phase_end(input string tag, input int exp_we, input int exp_done);
        repeat (4) @(negedge clk);
        chk({tag, "_writes_left"}, 32'(exp_addr.size()), 32'd0);
        chk({tag, "_done_left"}, 32'(exp_fin.size()), 32'd0);
        chk({tag, "_we_count"}, 32'(n_we), 32'(exp_we));
        chk({tag, "_done_count"}, 32'(n_done), 32'(exp_done));
        chk({tag, "_state_idle"}, 32'(state), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        trigger      = 1'b0;
        sample_valid = 1'b0;
        bank_release = 1'b0;
        release_bank = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_idx_final", 32'(idx_final), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_done", 32'(memorization_completed), 32'd0);
        chk("rst_full", 32'({bank0_full, bank1_full}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 10 high + 16 low strobes: bank 0 idx 0..25
        push_range(1'b0, 0, 25);
        exp_fin.push_back(8'd25);
        run_event(10, 16, -1, 1'b0);
        phase_end("basic", 26, 1);
        chk("basic_idx_final_hold", 32'(idx_final), 32'd25);

        // Trigger dip shorter than holdoff keeps one event; starts in bank 1
        push_range(1'b1, 0, 33);
        exp_fin.push_back(8'd33);
        run_event(5, 10, -1, 1'b0);
        run_event(3, 16, -1, 1'b0);
        phase_end("dip", 60, 2);

        // Wrap from bank 0 into pending bank 1 with a coincident release
        release_only(1'b0);
        push_range(1'b0, 0, 199);
        push_range(1'b1, 0, 16);
        exp_fin.push_back(8'd16);
        run_event(201, 16, 200, 1'b1);
        phase_end("rel_wrap", 277, 3);
        chk("rel_wrap_overflow", 32'(overflow), 32'd0);

        // Holdoff end lands exactly on idx 199: full pulse, no completion
        release_only(1'b0);
        push_range(1'b0, 0, 199);
        run_event(184, 16, -1, 1'b0);
        phase_end("edge_end", 477, 3);
        chk("edge_end_overflow", 32'(overflow), 32'd0);

        // Bank 1 still pending: every sample dropped
        run_event(2, 16, -1, 1'b0);
        phase_end("blocked", 477, 3);
        chk("blocked_overflow", 32'(overflow), 32'd1);

        reset = 1'b1;
        @(negedge clk);
        chk("rst2_overflow", 32'(overflow), 32'd0);
        chk("rst2_waddr", 32'(waddr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 450-sample event with bank 0 released while bank 1 fills
        push_range(1'b0, 0, 199);
        push_range(1'b1, 0, 199);
        push_range(1'b0, 0, 49);
        exp_fin.push_back(8'd49);
        run_event(434, 16, 300, 1'b0);
        phase_end("long", 927, 4);
        chk("long_overflow", 32'(overflow), 32'd0);
        chk("long_idx_final", 32'(idx_final), 32'd49);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
